radar_sweep_gen: RTL and testbench

- Parametrised radar signal generator for the sea-clutter STC path. Replaces the fixed-geometry radar source.
- Produces the trigger, ACP and ARP pulse trains. Produces range-gated video: LFSR sea-clutter noise, scaled by a runtime gain and attenuated with range (STC law).
- Drives downstream STC/display logic and CSV-dump benches.

---
 rtl/radar_sweep_gen.sv | 173 +++++++++++++++++
 tb/tb_radar_sweep_gen.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radar_sweep_gen.sv
// radar_sweep_gen: parametrised radar source for the sea-clutter STC path.
// Generates trigger / ACP / ARP pulse trains and range-gated LFSR clutter
// video, scaled by a runtime Q0.8 gain and attenuated with range (STC law).
// Optional build macro: RADAR_TARGET_INJECT_EN adds a point-target injector
// (inputs tgt_range / tgt_az) that forces full-scale video at the target cell.
module radar_sweep_gen #(
   parameter int          VIDEO_W      = 12,
   parameter int          PRI_CYCLES   = 2000,
   parameter int          TRIG_W       = 10,
   parameter int          RANGE_BINS   = 1024,
   parameter int          BIN_CYCLES   = 1,
   parameter int          TRIG_PER_ACP = 4,
   parameter int          ACP_PER_REV  = 4096,
   parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468,
   localparam int         BIN_W        = (RANGE_BINS  > 1) ? $clog2(RANGE_BINS)  : 1,
   localparam int         AZ_W         = (ACP_PER_REV > 1) ? $clog2(ACP_PER_REV) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [7:0]         clutter_gain,
`ifdef RADAR_TARGET_INJECT_EN
   input  logic [BIN_W-1:0]   tgt_range,
   input  logic [AZ_W-1:0]    tgt_az,
`endif
   output logic               trig,
   output logic               acp,
   output logic               arp,
   output logic [VIDEO_W-1:0] video,
   output logic               video_valid,
   output logic [BIN_W-1:0]   range_bin,
   output logic [AZ_W-1:0]    azimuth
);

   // Counter widths; cyc must be able to hold the exclusive window end value.
   localparam int CYC_W = $clog2(PRI_CYCLES + 1);
   localparam int SUB_W = (BIN_CYCLES   > 1) ? $clog2(BIN_CYCLES)   : 1;
   localparam int SWP_W = (TRIG_PER_ACP > 1) ? $clog2(TRIG_PER_ACP) : 1;

   localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(PRI_CYCLES - 1);
   localparam logic [CYC_W-1:0] WIN_START = CYC_W'(TRIG_W);
   localparam logic [CYC_W-1:0] WIN_END   = CYC_W'(TRIG_W + RANGE_BINS * BIN_CYCLES);
   localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(BIN_CYCLES - 1);
   localparam logic [BIN_W-1:0] BIN_LAST  = BIN_W'(RANGE_BINS - 1);
   localparam logic [SWP_W-1:0] SWP_LAST  = SWP_W'(TRIG_PER_ACP - 1);
   localparam logic [AZ_W-1:0]  ACP_LAST  = AZ_W'(ACP_PER_REV - 1);

   // A zero seed would lock the LFSR at zero forever, so fall back to the default.
   localparam logic [31:0] SEED = (LFSR_SEED == 32'd0) ? 32'hACE1_2468 : LFSR_SEED;

   // The trigger plus the whole range window must fit inside one sweep.
   if (TRIG_W + RANGE_BINS * BIN_CYCLES > PRI_CYCLES) begin : g_geom_check
      $error("radar_sweep_gen: TRIG_W + RANGE_BINS*BIN_CYCLES exceeds PRI_CYCLES");
   end

   logic [CYC_W-1:0]   cyc;
   logic [SUB_W-1:0]   bin_sub;
   logic [BIN_W-1:0]   bin;
   logic [SWP_W-1:0]   sweep;
   logic [AZ_W-1:0]    acp_cnt;
   logic [31:0]        lfsr;
   logic [VIDEO_W-1:0] samp;        // video of the current bin, survives en=0

   logic               in_win;
   logic               bin_first;
   logic               cyc_wrap;
   logic [31:0]        lfsr_next;
   logic [VIDEO_W+7:0] prod;
   logic [VIDEO_W-1:0] amp;
   logic [VIDEO_W-1:0] sample_val;
`ifdef RADAR_TARGET_INJECT_EN
   int                 az_d;
`endif

   // STC shift: position of the highest set bit of the bin index, clamped.
   function automatic int msb_idx(input logic [BIN_W-1:0] v);
      int r;
      r = 0;
      for (int i = 0; i < BIN_W; i++) begin
         if (v[i]) r = i;
      end
      if (r > VIDEO_W - 1) r = VIDEO_W - 1;
      return r;
   endfunction

   // Window decode and the clutter sample for the bin being started.
   always_comb begin
      // NOTE: every variable gets a value on every path before any condition, so no latch can be inferred.
      in_win     = (cyc >= WIN_START) && (cyc < WIN_END);
      bin_first  = in_win && (bin_sub == '0);
      cyc_wrap   = (cyc == CYC_LAST);
      lfsr_next  = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      prod       = {8'd0, lfsr[VIDEO_W-1:0]} * {{VIDEO_W{1'b0}}, clutter_gain};
      amp        = VIDEO_W'(prod >> 8);
      sample_val = amp >> msb_idx(bin);
`ifdef RADAR_TARGET_INJECT_EN
      az_d = int'(acp_cnt) - int'(tgt_az);
      if (az_d < 0) az_d = -az_d;
      if (ACP_PER_REV - az_d < az_d) az_d = ACP_PER_REV - az_d;
      if ((bin == tgt_range) && (az_d <= 2)) sample_val = '1;
`endif
   end

   // Timing counters, LFSR and held bin sample; everything freezes while en=0.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         cyc     <= '0;
         bin_sub <= '0;
         bin     <= '0;
         sweep   <= '0;
         acp_cnt <= '0;
         lfsr    <= SEED;
         samp    <= '0;
      end else if (en) begin
         cyc <= cyc_wrap ? '0 : cyc + 1'b1;
         if (cyc_wrap) begin
            sweep <= (sweep == SWP_LAST) ? '0 : sweep + 1'b1;
            if (sweep == SWP_LAST) acp_cnt <= (acp_cnt == ACP_LAST) ? '0 : acp_cnt + 1'b1;
         end
         if (in_win) begin
            if (bin_sub == SUB_LAST) begin
               bin_sub <= '0;
               bin     <= (bin == BIN_LAST) ? '0 : bin + 1'b1;
            end else begin
               bin_sub <= bin_sub + 1'b1;
            end
         end else begin
            bin_sub <= '0;
            bin     <= '0;
         end
         // The LFSR value consumed by a bin is the one present on its first cycle.
         if (bin_first) begin
            lfsr <= lfsr_next;
            samp <= sample_val;
         end
      end
   end

   // Registered outputs, one cycle behind the counter state; gated off while en=0.
   // A held cyc==0 was never emitted (emission and advance happen together), so no pulse repeats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig        <= 1'b0;
         acp         <= 1'b0;
         arp         <= 1'b0;
         video       <= '0;
         video_valid <= 1'b0;
         range_bin   <= '0;
         azimuth     <= '0;
      end else begin
         azimuth <= acp_cnt;
         if (en) begin
            trig        <= (cyc < WIN_START);
            acp         <= (cyc == '0) && (sweep == '0);
            arp         <= (cyc == '0) && (sweep == '0) && (acp_cnt == '0);
            video_valid <= in_win;
            range_bin   <= in_win ? bin : '0;
            if (!in_win)        video <= '0;
            else if (bin_first) video <= sample_val;
            else                video <= samp;
         end else begin
            trig        <= 1'b0;
            acp         <= 1'b0;
            arp         <= 1'b0;
            video_valid <= 1'b0;
            range_bin   <= '0;
            video       <= '0;
         end
      end
   end

endmodule

// File: tb/tb_radar_sweep_gen.sv
// tb_radar_sweep_gen: directed bench for radar_sweep_gen with the small
// geometry PRI=20, TRIG_W=2, 8 bins x 2 cycles, 2 sweeps/ACP, 3 ACP/rev.
// Expected values come from sweep-index formulas plus a spec-level LFSR model.
module tb_radar_sweep_gen;

   localparam int          VW   = 12;
   localparam logic [31:0] SEED = 32'hACE1_2468;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [7:0]  clutter_gain;
   logic        trig, acp, arp, video_valid;
   logic [11:0] video;
   logic [2:0]  range_bin;
   logic [1:0]  azimuth;
`ifdef RADAR_TARGET_INJECT_EN
   logic [2:0]  tgt_range;
   logic [1:0]  tgt_az;
`endif

   radar_sweep_gen #(
      .VIDEO_W(12), .PRI_CYCLES(20), .TRIG_W(2), .RANGE_BINS(8), .BIN_CYCLES(2),
      .TRIG_PER_ACP(2), .ACP_PER_REV(3), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .clutter_gain(clutter_gain),
`ifdef RADAR_TARGET_INJECT_EN
      .tgt_range(tgt_range), .tgt_az(tgt_az),
`endif
      .trig(trig), .acp(acp), .arp(arp), .video(video), .video_valid(video_valid),
      .range_bin(range_bin), .azimuth(azimuth)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model state: k counts enabled cycles since reset release.
   int          k;
   int          cur_cyc;
   logic [31:0] m_lfsr;
   logic [11:0] m_samp;
   logic        e_trig, e_acp, e_arp, e_valid;
   logic [2:0]  e_bin;
   logic [1:0]  e_az;
   logic [11:0] e_video;
   logic [11:0] first_run [20];

   function automatic int stc_shift(input int b);
      int r;
      r = 0;
      for (int i = 0; i < 3; i++) if (b[i]) r = i;
      return (r > VW - 1) ? VW - 1 : r;
   endfunction

`ifdef RADAR_TARGET_INJECT_EN
   function automatic int az_dist(input int a, input int b);
      int d;
      d = (a > b) ? a - b : b - a;
      return (3 - d < d) ? 3 - d : d;
   endfunction
`endif

   // Expected outputs for one enabled edge with the model at state k.
   task automatic model_step();
      int          bin;
      logic [19:0] p;
      cur_cyc = k % 20;
      e_trig  = cur_cyc < 2;
      e_acp   = (cur_cyc == 0) && ((k / 20) % 2 == 0);
      e_arp   = e_acp && ((k / 40) % 3 == 0);
      e_az    = 2'((k / 40) % 3);
      e_valid = (cur_cyc >= 2) && (cur_cyc <= 17);
      bin     = e_valid ? (cur_cyc - 2) / 2 : 0;
      e_bin   = 3'(bin);
      if (e_valid && (cur_cyc % 2 == 0)) begin
         p      = 20'(m_lfsr[11:0]) * 20'(clutter_gain);
         m_samp = p[19:8] >> stc_shift(bin);
`ifdef RADAR_TARGET_INJECT_EN
         if ((e_bin == tgt_range) && (az_dist((k / 40) % 3, int'(tgt_az)) <= 2)) m_samp = 12'hFFF;
`endif
         m_lfsr = {m_lfsr[30:0], m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0]};
      end
      e_video = e_valid ? m_samp : 12'd0;
      k++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_init();
      k      = 0;
      m_lfsr = SEED;
      m_samp = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      step();
      step();
      rst = 1'b0;
      model_init();
      en  = 1'b1;
   endtask

   task automatic test_reset();
      #50;
      checks++; if (trig !== 1'b0)        begin failures++; $display("FAIL reset_trig got=%b exp=0", trig); end
      checks++; if (acp !== 1'b0)         begin failures++; $display("FAIL reset_acp got=%b exp=0", acp); end
      checks++; if (arp !== 1'b0)         begin failures++; $display("FAIL reset_arp got=%b exp=0", arp); end
      checks++; if (video !== 12'd0)      begin failures++; $display("FAIL reset_video got=%0d exp=0", video); end
      checks++; if (video_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", video_valid); end
      checks++; if (range_bin !== 3'd0)   begin failures++; $display("FAIL reset_range_bin got=%0d exp=0", range_bin); end
      checks++; if (azimuth !== 2'd0)     begin failures++; $display("FAIL reset_azimuth got=%0d exp=0", azimuth); end
      #50;
      rst          = 1'b0;
      model_init();
      en           = 1'b1;
      clutter_gain = 8'd255;
   endtask

   // Pulse trains over two full revolutions.
   task automatic test_timing();
      for (int i = 0; i < 240; i++) begin
         step();
         model_step();
         checks++; if (trig !== e_trig)  begin failures++; $display("FAIL timing_trig k=%0d got=%b exp=%b", k-1, trig, e_trig); end
         checks++; if (acp !== e_acp)    begin failures++; $display("FAIL timing_acp k=%0d got=%b exp=%b", k-1, acp, e_acp); end
         checks++; if (arp !== e_arp)    begin failures++; $display("FAIL timing_arp k=%0d got=%b exp=%b", k-1, arp, e_arp); end
         checks++; if (azimuth !== e_az) begin failures++; $display("FAIL timing_azimuth k=%0d got=%0d exp=%0d", k-1, azimuth, e_az); end
      end
   endtask

   // Range window, bin sequence, LFSR video and STC bound.
   task automatic test_video();
      logic [11:0] prev;
      do_reset();
      clutter_gain = 8'd255;
      prev = '0;
      for (int i = 0; i < 40; i++) begin
         step();
         model_step();
         if (i < 20) first_run[i] = video;
         checks++; if (video_valid !== e_valid) begin failures++; $display("FAIL video_valid k=%0d got=%b exp=%b", k-1, video_valid, e_valid); end
         checks++; if (range_bin !== e_bin)     begin failures++; $display("FAIL video_bin k=%0d got=%0d exp=%0d", k-1, range_bin, e_bin); end
         checks++; if (video !== e_video)       begin failures++; $display("FAIL video_value k=%0d got=%0d exp=%0d", k-1, video, e_video); end
         if (e_valid && e_bin == 3'd4) begin
            checks++; if (video > 12'd1023) begin failures++; $display("FAIL video_stc_bin4 k=%0d got=%0d max=1023", k-1, video); end
         end
         if (e_valid && (cur_cyc % 2 == 1)) begin
            checks++; if (video !== prev) begin failures++; $display("FAIL video_hold k=%0d got=%0d exp=%0d", k-1, video, prev); end
         end
         prev = video;
      end
   endtask

   // Zero gain silences video; a mid-bin gain change waits for the next bin.
   task automatic test_gain();
      do_reset();
      clutter_gain = 8'd0;
      for (int i = 0; i < 20; i++) begin
         step();
         model_step();
         checks++; if (video !== 12'd0)         begin failures++; $display("FAIL gain0_video k=%0d got=%0d exp=0", k-1, video); end
         checks++; if (video_valid !== e_valid) begin failures++; $display("FAIL gain0_valid k=%0d got=%b exp=%b", k-1, video_valid, e_valid); end
      end
      do_reset();
      clutter_gain = 8'd255;
      for (int i = 0; i < 3; i++) begin
         step();
         model_step();
      end
      // Seed low 12 bits 0x468=1128; (1128*255)>>8 = 1123, bin 0 has no STC shift.
      checks++; if (video !== 12'd1123) begin failures++; $display("FAIL gain_bin0_first got=%0d exp=1123", video); end
      clutter_gain = 8'd0;
      step();
      model_step();
      checks++; if (video !== 12'd1123) begin failures++; $display("FAIL gain_midbin_hold got=%0d exp=1123", video); end
      step();
      model_step();
      checks++; if (video !== 12'd0)    begin failures++; $display("FAIL gain_next_bin got=%0d exp=0", video); end
   endtask

   // Enable gating mid-window and on a pending cyc==0 pulse.
   task automatic test_enable_gating();
      do_reset();
      clutter_gain = 8'd255;
      for (int i = 0; i < 7; i++) begin
         step();
         model_step();
      end
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++; if ({trig, acp, arp, video_valid} !== 4'b0000) begin failures++; $display("FAIL gate_pulses i=%0d got=%b exp=0000", i, {trig, acp, arp, video_valid}); end
         checks++; if (video !== 12'd0) begin failures++; $display("FAIL gate_video i=%0d got=%0d exp=0", i, video); end
      end
      en = 1'b1;
      step();
      model_step();
      checks++; if (range_bin !== 3'd2)   begin failures++; $display("FAIL gate_resume_bin got=%0d exp=2", range_bin); end
      checks++; if (video !== e_video)    begin failures++; $display("FAIL gate_resume_video got=%0d exp=%0d", video, e_video); end
      checks++; if (video_valid !== 1'b1) begin failures++; $display("FAIL gate_resume_valid got=%b exp=1", video_valid); end
      for (int i = 8; i < 40; i++) begin
         step();
         model_step();
         checks++; if (trig !== e_trig)     begin failures++; $display("FAIL gate_trig k=%0d got=%b exp=%b", k-1, trig, e_trig); end
         checks++; if (acp !== e_acp)       begin failures++; $display("FAIL gate_acp k=%0d got=%b exp=%b", k-1, acp, e_acp); end
         checks++; if (range_bin !== e_bin) begin failures++; $display("FAIL gate_bin k=%0d got=%0d exp=%0d", k-1, range_bin, e_bin); end
         checks++; if (video !== e_video)   begin failures++; $display("FAIL gate_video_run k=%0d got=%0d exp=%0d", k-1, video, e_video); end
      end
      // State now sits at cyc=0 of sweep 0 (ACP pending); hold it, then release.
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (acp !== 1'b0) begin failures++; $display("FAIL gate_hold_acp i=%0d got=%b exp=0", i, acp); end
      end
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         model_step();
         checks++; if (acp !== e_acp)    begin failures++; $display("FAIL gate_release_acp k=%0d got=%b exp=%b", k-1, acp, e_acp); end
         checks++; if (azimuth !== e_az) begin failures++; $display("FAIL gate_release_az k=%0d got=%0d exp=%0d", k-1, azimuth, e_az); end
      end
   endtask

   // Asynchronous reset mid-window at azimuth 1, then a replay of the first sweep.
   task automatic test_reset_mid();
      do_reset();
      clutter_gain = 8'd255;
      for (int i = 0; i < 50; i++) begin
         step();
         model_step();
      end
      checks++; if (azimuth !== 2'd1 || video_valid !== 1'b1) begin failures++; $display("FAIL rmid_pre az=%0d valid=%b exp az=1 valid=1", azimuth, video_valid); end
      rst = 1'b1;
      #2;
      checks++; if ({trig, acp, arp, video_valid} !== 4'b0000) begin failures++; $display("FAIL rmid_async_pulses got=%b exp=0000", {trig, acp, arp, video_valid}); end
      checks++; if (video !== 12'd0 || range_bin !== 3'd0 || azimuth !== 2'd0) begin failures++; $display("FAIL rmid_async_data video=%0d bin=%0d az=%0d exp all 0", video, range_bin, azimuth); end
      step();
      rst = 1'b0;
      model_init();
      for (int i = 0; i < 20; i++) begin
         step();
         model_step();
         checks++; if (video !== first_run[i]) begin failures++; $display("FAIL rmid_replay i=%0d got=%0d exp=%0d", i, video, first_run[i]); end
         checks++; if (arp !== e_arp)          begin failures++; $display("FAIL rmid_arp i=%0d got=%b exp=%b", i, arp, e_arp); end
      end
   endtask

`ifdef RADAR_TARGET_INJECT_EN
   // Target at bin 5, azimuth 0: with 3 ACPs per rev every azimuth is within +-2.
   task automatic test_target();
      tgt_range = 3'd5;
      tgt_az    = 2'd0;
      do_reset();
      clutter_gain = 8'd255;
      for (int i = 0; i < 120; i++) begin
         step();
         model_step();
         if (e_valid && e_bin == 3'd5) begin
            checks++; if (video !== 12'hFFF) begin failures++; $display("FAIL target_hit k=%0d got=%0d exp=4095", k-1, video); end
         end else begin
            checks++; if (video !== e_video) begin failures++; $display("FAIL target_clutter k=%0d got=%0d exp=%0d", k-1, video, e_video); end
         end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      en           = 1'b0;
      clutter_gain = 8'd0;
`ifdef RADAR_TARGET_INJECT_EN
      tgt_range    = 3'd0;
      tgt_az       = 2'd0;
`endif
      test_reset();
      test_timing();
      test_video();
      test_gain();
      test_enable_gating();
      test_reset_mid();
`ifdef RADAR_TARGET_INJECT_EN
      test_target();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
